// File: rtl/ofs_fim_pcie_hdr_split_if.sv
// Stream bundle for the PCIe SS TLP header/data splitter: source in, header out, data out.
// master = the environment around the splitter, slave = the splitter itself.
interface ofs_fim_pcie_hdr_split_if #(
    parameter int TDATA_W = 512,
    parameter int HDR_W   = 256,
    parameter int TUSER_W = 10
);
    logic                   s_tvalid;
    logic                   s_tready;
    logic [TDATA_W-1:0]     s_tdata;
    logic [TDATA_W/8-1:0]   s_tkeep;
    logic                   s_tlast;
    logic [TUSER_W-1:0]     s_tuser;

    logic                   h_tvalid;
    logic                   h_tready;
    logic [HDR_W-1:0]       h_tdata;
    logic [TUSER_W-1:0]     h_tuser;
    logic                   h_has_data;

    logic                   d_tvalid;
    logic                   d_tready;
    logic [TDATA_W-1:0]     d_tdata;
    logic [TDATA_W/8-1:0]   d_tkeep;
    logic                   d_tlast;
    logic [15:0]            d_byte_cnt;

    modport master (
        output s_tvalid, s_tdata, s_tkeep, s_tlast, s_tuser, h_tready, d_tready,
        input  s_tready, h_tvalid, h_tdata, h_tuser, h_has_data,
        input  d_tvalid, d_tdata, d_tkeep, d_tlast, d_byte_cnt
    );

    modport slave (
        input  s_tvalid, s_tdata, s_tkeep, s_tlast, s_tuser, h_tready, d_tready,
        output s_tready, h_tvalid, h_tdata, h_tuser, h_has_data,
        output d_tvalid, d_tdata, d_tkeep, d_tlast, d_byte_cnt
    );
endinterface

// File: rtl/ofs_fim_pcie_hdr_split.sv
// Splits the in-band TLP header onto a FIFO-backed header stream and re-aligns payload to bit 0.
// Optional feature: define OFS_FIM_PCIE_HDR_SPLIT_BYTE_CNT_EN to enable the payload byte counter.
module ofs_fim_pcie_hdr_split #(
    parameter int TDATA_W        = 512,
    parameter int HDR_W          = 256,
    parameter int TUSER_W        = 10,
    parameter int HDR_FIFO_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    ofs_fim_pcie_hdr_split_if.slave             bus,
    output logic [$clog2(HDR_FIFO_DEPTH):0]     hdr_fifo_cnt
);
    localparam int KW = TDATA_W / 8;
    localparam int HK = HDR_W / 8;
    localparam int UW = TDATA_W - HDR_W;
    localparam int UK = KW - HK;
    localparam int AW = $clog2(HDR_FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = HDR_W + TUSER_W + 1;

    localparam logic [1:0] ST_SOP   = 2'd0;
    localparam logic [1:0] ST_BODY  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [UW-1:0]      prev_data_q, prev_data_d;
    logic [UK-1:0]      prev_keep_q, prev_keep_d;

    logic               d_tvalid_q, d_tvalid_d;
    logic [TDATA_W-1:0] d_tdata_q, d_tdata_d;
    logic [KW-1:0]      d_tkeep_q, d_tkeep_d;
    logic               d_tlast_q, d_tlast_d;

    logic [EW-1:0]      h_ent_q, h_ent_d;
    logic               h_tvalid_q, h_tvalid_d;
    logic [EW-1:0]      hdr_mem [HDR_FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      arr_cnt_q, arr_cnt_d;

    logic               s_tready_c;
    logic               acc;
    logic               d_free;
    logic               fifo_full;
    logic               upper_has;
    logic               push;
    logic               pop;
    logic               out_load;
    logic               mem_we;
    logic               d_load;
    logic [EW-1:0]      push_ent;

    assign upper_has    = |bus.s_tkeep[KW-1:HK];
    assign d_free       = !d_tvalid_q || bus.d_tready;
    assign hdr_fifo_cnt = arr_cnt_q + CW'(h_tvalid_q);
    assign fifo_full    = (hdr_fifo_cnt == CW'(HDR_FIFO_DEPTH));
    assign s_tready_c   = rst_n && (((state_q == ST_SOP) && !fifo_full && d_free) ||
                                    ((state_q == ST_BODY) && d_free));
    assign acc          = bus.s_tvalid && s_tready_c;
    assign push         = acc && (state_q == ST_SOP);
    assign pop          = h_tvalid_q && bus.h_tready;
    assign out_load     = !h_tvalid_q || pop;
    assign push_ent     = {bus.s_tdata[HDR_W-1:0], bus.s_tuser, upper_has};

    always_comb begin
        state_d     = state_q;
        prev_data_d = prev_data_q;
        prev_keep_d = prev_keep_q;
        d_tvalid_d  = d_tvalid_q && !bus.d_tready;
        d_tdata_d   = d_tdata_q;
        d_tkeep_d   = d_tkeep_q;
        d_tlast_d   = d_tlast_q;
        d_load      = 1'b0;
        case (state_q)
            ST_SOP: begin
                if (acc) begin
                    if (!bus.s_tlast) begin
                        state_d = ST_BODY;
                    end else if (upper_has) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_BODY: begin
                if (acc) begin
                    d_load    = 1'b1;
                    d_tdata_d = {bus.s_tdata[HDR_W-1:0], prev_data_q};
                    d_tkeep_d = {bus.s_tkeep[HK-1:0], prev_keep_q};
                    // A last beat with upper bytes left over needs one more beat from DRAIN
                    d_tlast_d = bus.s_tlast && !upper_has;
                    if (bus.s_tlast) begin
                        state_d = upper_has ? ST_DRAIN : ST_SOP;
                    end
                end
            end
            ST_DRAIN: begin
                if (d_free) begin
                    d_load    = 1'b1;
                    d_tdata_d = {{HDR_W{1'b0}}, prev_data_q};
                    d_tkeep_d = {{HK{1'b0}}, prev_keep_q};
                    d_tlast_d = 1'b1;
                    state_d   = ST_SOP;
                end
            end
            default: state_d = ST_SOP;
        endcase
        if (d_load) begin
            d_tvalid_d = 1'b1;
        end
        if (acc) begin
            prev_data_d = bus.s_tdata[TDATA_W-1:HDR_W];
            prev_keep_d = bus.s_tkeep[KW-1:HK];
        end
    end

    // Header FIFO: array behind a registered head; an empty array lets a push bypass to the head.
    always_comb begin
        h_ent_d    = h_ent_q;
        h_tvalid_d = h_tvalid_q && !pop;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        arr_cnt_d  = arr_cnt_q;
        mem_we     = 1'b0;
        if (out_load) begin
            if (arr_cnt_q != '0) begin
                h_ent_d    = hdr_mem[rd_ptr_q];
                h_tvalid_d = 1'b1;
                rd_ptr_d   = rd_ptr_q + 1'b1;
                arr_cnt_d  = arr_cnt_d - 1'b1;
            end else if (push) begin
                h_ent_d    = push_ent;
                h_tvalid_d = 1'b1;
            end
        end
        if (push && !(out_load && (arr_cnt_q == '0))) begin
            mem_we    = 1'b1;
            wr_ptr_d  = wr_ptr_q + 1'b1;
            arr_cnt_d = arr_cnt_d + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            hdr_mem[wr_ptr_q] <= push_ent;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_SOP;
            prev_data_q <= '0;
            prev_keep_q <= '0;
            d_tvalid_q  <= 1'b0;
            d_tdata_q   <= '0;
            d_tkeep_q   <= '0;
            d_tlast_q   <= 1'b0;
            h_ent_q     <= '0;
            h_tvalid_q  <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            arr_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            prev_data_q <= prev_data_d;
            prev_keep_q <= prev_keep_d;
            d_tvalid_q  <= d_tvalid_d;
            d_tdata_q   <= d_tdata_d;
            d_tkeep_q   <= d_tkeep_d;
            d_tlast_q   <= d_tlast_d;
            h_ent_q     <= h_ent_d;
            h_tvalid_q  <= h_tvalid_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            arr_cnt_q   <= arr_cnt_d;
        end
    end

`ifdef OFS_FIM_PCIE_HDR_SPLIT_BYTE_CNT_EN
    logic [15:0] byte_cnt_q, byte_cnt_d;
    logic [15:0] beat_bytes;

    always_comb begin
        beat_bytes = '0;
        for (int i = 0; i < KW; i++) begin
            beat_bytes = beat_bytes + 16'(d_tkeep_d[i]);
        end
        byte_cnt_d = byte_cnt_q;
        if (d_tvalid_q && bus.d_tready && d_tlast_q) begin
            byte_cnt_d = '0;
        end
        if (d_load) begin
            byte_cnt_d = byte_cnt_d + beat_bytes;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_cnt_q <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
        end
    end

    assign bus.d_byte_cnt = byte_cnt_q;
`else
    assign bus.d_byte_cnt = '0;
`endif

    assign bus.s_tready   = s_tready_c;
    assign bus.h_tvalid   = h_tvalid_q;
    assign bus.h_tdata    = h_ent_q[EW-1 -: HDR_W];
    assign bus.h_tuser    = h_ent_q[TUSER_W:1];
    assign bus.h_has_data = h_ent_q[0];
    assign bus.d_tvalid   = d_tvalid_q;
    assign bus.d_tdata    = d_tdata_q;
    assign bus.d_tkeep    = d_tkeep_q;
    assign bus.d_tlast    = d_tlast_q;
endmodule

// File: tb/tb_ofs_fim_pcie_hdr_split.sv
// Self-checking bench for ofs_fim_pcie_hdr_split: vector table, hand sequences, random traffic
// against a byte-stream model of header extraction and payload repacking.
module tb_ofs_fim_pcie_hdr_split;
    localparam int TDATA_W = 512;
    localparam int HDR_W   = 256;
    localparam int TUSER_W = 10;
    localparam int DEPTH   = 4;
    localparam int KW      = TDATA_W / 8;
    localparam int HK      = HDR_W / 8;
`ifdef OFS_FIM_PCIE_HDR_SPLIT_BYTE_CNT_EN
    localparam bit BC_EN = 1'b1;
`else
    localparam bit BC_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [2:0] hdr_fifo_cnt;
    always #5 clk = ~clk;

    ofs_fim_pcie_hdr_split_if #(.TDATA_W(TDATA_W), .HDR_W(HDR_W), .TUSER_W(TUSER_W)) bus ();

    ofs_fim_pcie_hdr_split #(
        .TDATA_W(TDATA_W), .HDR_W(HDR_W), .TUSER_W(TUSER_W), .HDR_FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .hdr_fifo_cnt(hdr_fifo_cnt)
    );

    typedef logic [HDR_W+TUSER_W:0] hexp_t;
    typedef struct packed {
        logic [TDATA_W-1:0] data;
        logic [KW-1:0]      keep;
        logic               last;
        logic [15:0]        bytes;
    } dexp_t;
    typedef struct {
        int           nbeats;
        logic [63:0]  last_keep;
        logic         exp_has;
        int           exp_dbeats;
        logic [63:0]  exp_last_dkeep;
        logic [15:0]  exp_bytes;
    } vec_t;

    hexp_t exp_h[$];
    dexp_t exp_d[$];
    int total = 0;
    int bad   = 0;
    int hdr_seen = 0;
    int d_seen   = 0;
    logic        last_has;
    logic [63:0] last_dkeep;
    logic        last_dlast;
    logic [15:0] last_bytes;
    int h_mode = 1;
    int d_mode = 1;
    hexp_t mon_hgot, mon_he;
    dexp_t mon_dgot, mon_de;

    logic [TDATA_W-1:0] pk_data [8];
    logic [KW-1:0]      pk_keep [8];
    int                 pk_nb;
    logic [TUSER_W-1:0] pk_user;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Ready generators: 0 = hold low, 1 = hold high, 2 = random, 3 = toggle
    always @(posedge clk) begin
        #1;
        case (h_mode)
            0: bus.h_tready = 1'b0;
            1: bus.h_tready = 1'b1;
            2: bus.h_tready = ($urandom_range(0, 9) < 7);
            default: bus.h_tready = !bus.h_tready;
        endcase
        case (d_mode)
            0: bus.d_tready = 1'b0;
            1: bus.d_tready = 1'b1;
            2: bus.d_tready = ($urandom_range(0, 9) < 7);
            default: bus.d_tready = !bus.d_tready;
        endcase
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.h_tvalid && bus.h_tready) begin
                total++;
                hdr_seen++;
                last_has = bus.h_has_data;
                mon_hgot = {bus.h_tdata, bus.h_tuser, bus.h_has_data};
                if (exp_h.size() == 0) begin
                    bad++;
                    $display("FAIL hdr_unexpected: got %0h expected none", mon_hgot);
                end else begin
                    mon_he = exp_h.pop_front();
                    if (mon_hgot !== mon_he) begin
                        bad++;
                        $display("FAIL hdr_stream: got %0h expected %0h", mon_hgot, mon_he);
                    end
                end
            end
            if (bus.d_tvalid && bus.d_tready) begin
                total++;
                d_seen++;
                last_dkeep = bus.d_tkeep;
                last_dlast = bus.d_tlast;
                last_bytes = bus.d_byte_cnt;
                mon_dgot = {bus.d_tdata, bus.d_tkeep, bus.d_tlast,
                            bus.d_tlast ? bus.d_byte_cnt : 16'd0};
                if (exp_d.size() == 0) begin
                    bad++;
                    $display("FAIL data_unexpected: got %0h expected none", mon_dgot);
                end else begin
                    mon_de = exp_d.pop_front();
                    if (mon_dgot !== mon_de) begin
                        bad++;
                        $display("FAIL data_stream: got %0h expected %0h", mon_dgot, mon_de);
                    end
                end
            end
        end
    end

    // Random packet; bytes not enabled by tkeep are zero
    task automatic gen_pkt(input int nb, input logic [63:0] last_keep);
        pk_nb   = nb;
        pk_user = TUSER_W'($urandom);
        for (int b = 0; b < nb; b++) begin
            pk_keep[b] = (b == nb - 1) ? last_keep : {KW{1'b1}};
            for (int w = 0; w < TDATA_W / 32; w++) pk_data[b][32*w +: 32] = $urandom;
            for (int k = 0; k < KW; k++) if (!pk_keep[b][k]) pk_data[b][8*k +: 8] = 8'h00;
        end
    endtask

    // Reference: header = first HK bytes; payload = all remaining enabled bytes, repacked from byte 0
    task automatic model_push();
        logic [7:0] pay[$];
        dexp_t e;
        int i;
        for (int b = 0; b < pk_nb; b++)
            for (int k = 0; k < KW; k++)
                if (pk_keep[b][k] && !(b == 0 && k < HK)) pay.push_back(pk_data[b][8*k +: 8]);
        exp_h.push_back({pk_data[0][HDR_W-1:0], pk_user, pay.size() != 0});
        i = 0;
        while (i < pay.size()) begin
            e = '0;
            for (int k = 0; k < KW && i < pay.size(); k++) begin
                e.data[8*k +: 8] = pay[i];
                e.keep[k] = 1'b1;
                i++;
            end
            e.last  = (i == pay.size());
            e.bytes = (e.last && BC_EN) ? 16'(pay.size()) : 16'd0;
            exp_d.push_back(e);
        end
    endtask

    task automatic put_beat(input int b);
        bus.s_tvalid = 1'b1;
        bus.s_tdata  = pk_data[b];
        bus.s_tkeep  = pk_keep[b];
        bus.s_tlast  = (b == pk_nb - 1);
        bus.s_tuser  = pk_user;
    endtask

    task automatic drive_beat(input int b);
        int t;
        t = 0;
        put_beat(b);
        forever begin
            @(negedge clk);
            if (bus.s_tready) break;
            t++;
            if (t > 500) begin
                total++;
                bad++;
                $display("FAIL s_accept_timeout: got no accept expected accept within 500 cycles");
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.s_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input int gap);
        model_push();
        for (int b = 0; b < pk_nb; b++) begin
            drive_beat(b);
            repeat ($urandom_range(0, gap)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((exp_h.size() != 0 || exp_d.size() != 0) && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        total++;
        if (t >= 3000) begin
            bad++;
            $display("FAIL drain_timeout: got %0d hdr %0d data pending expected 0 0",
                     exp_h.size(), exp_d.size());
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    vec_t tv [6];
    int h0, d0, p, cur, nbytes;
    logic [TDATA_W+KW:0] snap;
    logic [63:0] lk;

    initial begin
        tv[0] = '{1, 64'h0000_0000_FFFF_FFFF, 1'b0, 0, 64'h0, 16'd0};
        tv[1] = '{1, 64'h0000_00FF_FFFF_FFFF, 1'b1, 1, 64'h0000_0000_0000_00FF, 16'd8};
        tv[2] = '{3, 64'h0000_0000_FFFF_FFFF, 1'b1, 2, 64'hFFFF_FFFF_FFFF_FFFF, 16'd128};
        tv[3] = '{2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 2, 64'h0000_0000_FFFF_FFFF, 16'd96};
        tv[4] = '{1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1, 64'h0000_0000_FFFF_FFFF, 16'd32};
        tv[5] = '{2, 64'h0000_0000_0000_FFFF, 1'b1, 1, 64'h0000_FFFF_FFFF_FFFF, 16'd48};

        bus.s_tvalid = 1'b0;
        bus.s_tdata  = '0;
        bus.s_tkeep  = '0;
        bus.s_tlast  = 1'b0;
        bus.s_tuser  = '0;
        repeat (3) cycle();

        @(negedge clk);
        chk("rst_s_tready", 64'(bus.s_tready), 64'd0);
        chk("rst_h_tvalid", 64'(bus.h_tvalid), 64'd0);
        chk("rst_d_tvalid", 64'(bus.d_tvalid), 64'd0);
        chk("rst_d_tlast", 64'(bus.d_tlast), 64'd0);
        chk("rst_fifo_cnt", 64'(hdr_fifo_cnt), 64'd0);
        chk("rst_byte_cnt", 64'(bus.d_byte_cnt), 64'd0);
        chk("rst_d_tdata_zero", 64'(|bus.d_tdata), 64'd0);
        cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_s_tready", 64'(bus.s_tready), 64'd1);
        cycle();

        for (int i = 0; i < 6; i++) begin
            h0 = hdr_seen;
            d0 = d_seen;
            gen_pkt(tv[i].nbeats, tv[i].last_keep);
            send_pkt(0);
            wait_idle();
            chk($sformatf("v%0d_hdr_count", i), 64'(hdr_seen - h0), 64'd1);
            chk($sformatf("v%0d_has_data", i), 64'(last_has), 64'(tv[i].exp_has));
            chk($sformatf("v%0d_data_beats", i), 64'(d_seen - d0), 64'(tv[i].exp_dbeats));
            if (tv[i].exp_dbeats > 0) begin
                chk($sformatf("v%0d_last_dkeep", i), last_dkeep, tv[i].exp_last_dkeep);
                chk($sformatf("v%0d_last_dlast", i), 64'(last_dlast), 64'd1);
                chk($sformatf("v%0d_byte_cnt", i), 64'(last_bytes),
                    BC_EN ? 64'(tv[i].exp_bytes) : 64'd0);
            end
        end

        // Header-only packets against a stalled header consumer
        h_mode = 0;
        cycle();
        cycle();
        p = 0;
        cur = -1;
        for (int c = 0; c < 8; c++) begin
            if (cur != p) begin
                gen_pkt(1, 64'h0000_0000_FFFF_FFFF);
                cur = p;
            end
            put_beat(0);
            @(negedge clk);
            chk($sformatf("s4_ready_cyc%0d", c), 64'(bus.s_tready), 64'(c < 4));
            if (bus.s_tready) begin
                model_push();
                p++;
            end
            cycle();
        end
        chk("s4_accepted", 64'(p), 64'd4);
        chk("s4_fifo_cnt_full", 64'(hdr_fifo_cnt), 64'd4);
        h_mode = 1;
        model_push();
        drive_beat(0);
        gen_pkt(1, 64'h0000_0000_FFFF_FFFF);
        model_push();
        drive_beat(0);
        wait_idle();
        chk("s4_fifo_cnt_empty", 64'(hdr_fifo_cnt), 64'd0);

        // Data consumer stalled mid-packet while the header consumer toggles
        gen_pkt(3, 64'h0000_0000_FFFF_FFFF);
        model_push();
        drive_beat(0);
        d_mode = 0;
        cycle();
        drive_beat(1);
        put_beat(2);
        h_mode = 3;
        @(negedge clk);
        chk("s5_d_tvalid", 64'(bus.d_tvalid), 64'd1);
        snap = {bus.d_tdata, bus.d_tkeep, bus.d_tlast};
        for (int c = 0; c < 5; c++) begin
            cycle();
            @(negedge clk);
            chk($sformatf("s5_s_tready_cyc%0d", c), 64'(bus.s_tready), 64'd0);
            chk($sformatf("s5_hold_cyc%0d", c),
                64'({bus.d_tvalid, bus.d_tdata, bus.d_tkeep, bus.d_tlast} === {1'b1, snap}), 64'd1);
        end
        cycle();
        d_mode = 1;
        h_mode = 1;
        drive_beat(2);
        wait_idle();

        // Reset pulse while in BODY with a header and a data beat pending
        h_mode = 0;
        d_mode = 0;
        cycle();
        cycle();
        gen_pkt(3, 64'hFFFF_FFFF_FFFF_FFFF);
        model_push();
        drive_beat(0);
        drive_beat(1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("s6_s_tready_in_rst", 64'(bus.s_tready), 64'd0);
        cycle();
        rst_n = 1'b1;
        exp_h.delete();
        exp_d.delete();
        @(negedge clk);
        chk("s6_h_tvalid", 64'(bus.h_tvalid), 64'd0);
        chk("s6_d_tvalid", 64'(bus.d_tvalid), 64'd0);
        chk("s6_fifo_cnt", 64'(hdr_fifo_cnt), 64'd0);
        cycle();
        h_mode = 1;
        d_mode = 1;
        cycle();
        h0 = hdr_seen;
        gen_pkt(1, 64'h0000_0000_FFFF_FFFF);
        send_pkt(0);
        wait_idle();
        chk("s6_hdr_after_rst", 64'(hdr_seen - h0), 64'd1);

        // Random traffic with random back-pressure on both outputs
        h_mode = 2;
        d_mode = 2;
        for (int n = 0; n < 40; n++) begin
            p = $urandom_range(1, 4);
            if (p == 1) nbytes = ($urandom_range(0, 2) == 0) ? 32 : $urandom_range(32, 64);
            else        nbytes = $urandom_range(1, 64);
            lk = (nbytes == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << nbytes) - 64'd1);
            gen_pkt(p, lk);
            send_pkt(2);
        end
        wait_idle();
        h_mode = 1;
        d_mode = 1;
        cycle();
        cycle();
        chk("rand_fifo_cnt_empty", 64'(hdr_fifo_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ofs_fim_pcie_hdr_split.md
# ofs_fim_pcie_hdr_split

Parametrised splitter for PCIe SS TLP streams. It strips the in-band header from each packet onto a dedicated header stream backed by a FIFO, and re-aligns the payload to bit 0 of a separate data stream. It sits between the PCIe SS RX/TX AXI-S port and the header/data consumers (AFU shims, MMIO/DMA bridges).

Unlike the fixed-width generation, this block has the following properties:
- Configurable data and header widths.
- A configurable-depth header FIFO.
- Input stalls only on the resource actually needed.
- Header-only packets produce no data beat.
- Each header carries a has-data flag.

## Interface
- TDATA_W, 512: stream data width in bits; multiple of 64, greater than HDR_W.
- HDR_W, 256: header width in bits; multiple of 8. Headers always start at tdata[0].
- TUSER_W, 10: tuser_vendor width.
- HDR_FIFO_DEPTH, 4: header FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- s_tvalid / s_tready  in/out  1  source handshake.
- s_tdata  in  TDATA_W  source data.
- s_tkeep  in  TDATA_W/8  source byte enables.
- s_tlast  in  1  end of packet.
- s_tuser  in  TUSER_W  tuser_vendor.
- h_tvalid / h_tready  out/in  1  header stream handshake.
- h_tdata  out  HDR_W  header.
- h_tuser  out  TUSER_W  tuser from the SOP beat.
- h_has_data  out  1  1 when the packet has payload bytes after the header.
- d_tvalid / d_tready  out/in  1  data stream handshake.
- d_tdata  out  TDATA_W  re-aligned payload.
- d_tkeep  out  TDATA_W/8  re-aligned byte enables.
- d_tlast  out  1  last payload beat.
- d_byte_cnt  out  16  payload byte count, valid on the d_tlast beat (see Configuration).
- hdr_fifo_cnt  out  $clog2(HDR_FIFO_DEPTH)+1  header FIFO occupancy.

## Operation
- Definitions:
  - HK = HDR_W/8.
  - Upper part of a beat: bytes at index HK and above.
  - acc = s_tvalid && s_tready.
  - d_free = !d_tvalid || d_tready.
- Input beat register prev_data / prev_keep captures s_tdata / s_tkeep on every acc.
- State machine SOP, BODY, DRAIN; reset state is SOP.
- SOP state:
  - s_tready = (hdr FIFO not full) && d_free.
  - On acc, push {tdata[HDR_W-1:0], tuser, has_data} to the FIFO. has_data = |s_tkeep[TDATA_W/8-1:HK].
  - !tlast goes to BODY.
  - tlast && has_data goes to DRAIN.
  - tlast && !has_data stays in SOP; no data beat is emitted.
- BODY state:
  - s_tready = d_free.
  - On acc, load the data register: tdata = {s_tdata[HDR_W-1:0], prev_data[TDATA_W-1:HDR_W]}, keep formed the same way.
  - On a tlast beat whose upper part is empty: d_tlast = 1, go to SOP.
  - On a tlast beat whose upper part is non-empty: d_tlast = 0, go to DRAIN.
  - On a non-tlast beat: d_tlast = 0, stay in BODY.
- DRAIN state:
  - s_tready = 0.
  - When d_free, load tdata = {HDR_W zeros, prev_data[TDATA_W-1:HDR_W]} with the keep upper HK bits = 0, and d_tlast = 1.
  - Go to SOP.
- Header FIFO:
  - Synchronous, first-word fall-through from the registered output.
  - Simultaneous push and pop when full is not possible, because push requires not full.
  - Simultaneous push and pop when empty is allowed. The new entry appears next cycle.
- The data register is a single stage. d_tvalid is held, and d_tdata, d_tkeep, d_tlast are stable while d_tvalid && !d_tready.
- Header and data streams are independent. The consumer pairs them in order, using h_has_data to decide whether to read data until d_tlast.
- Input protocol violations (non-contiguous tkeep, tkeep gaps) are unchecked. Behaviour under them is undefined but must not deadlock.

## Timing
- Reset values:
  - s_tready = 0 during reset.
  - h_tvalid = 0, d_tvalid = 0, d_tlast = 0.
  - hdr_fifo_cnt = 0, d_byte_cnt = 0.
  - Data outputs are 0.
- Latency:
  - Header: SOP acc at cycle N gives h_tvalid at N+1.
  - Data beat from a BODY acc at N: d_tvalid at N+1.
  - DRAIN beat: one cycle after entering DRAIN, assuming d_free.
- Throughput:
  - Multi-beat packets: 1 input beat per cycle.
  - DRAIN costs one input bubble per packet whose last beat has a non-empty upper part.
  - Back-to-back header-only packets: 1 per cycle while the FIFO is not full.
- A full header FIFO stalls only SOP beats. BODY and DRAIN proceed.
- Reset mid-packet: FIFO and data register are flushed, state returns to SOP, and the next accepted beat is treated as SOP.

## Configuration
- OFS_FIM_PCIE_HDR_SPLIT_BYTE_CNT_EN defined:
  - A 16-bit counter sums popcount(d_tkeep) of each loaded data beat.
  - d_byte_cnt presents the packet total on the d_tlast beat and is held stable with it.
  - The counter clears after the d_tlast handshake.
- Not defined: d_byte_cnt is tied to 0 and no counter logic is generated.

## Test plan
All scenarios use TDATA_W=512, HDR_W=256.

1. Single-beat packet with tkeep=64'h0000_0000_FFFF_FFFF:
   - One header with h_has_data=0.
   - No data beat.
   - Next SOP is accepted the following cycle.
2. Single-beat packet with tkeep=64'h0000_00FF_FFFF_FFFF:
   - h_has_data=1.
   - One DRAIN beat with d_tkeep=64'h0000_0000_0000_00FF and d_tlast=1.
   - d_byte_cnt=8 with the macro defined.
3. Three-beat packet, full keep, last beat tkeep=64'hFFFF_FFFF:
   - Two data beats with full keep.
   - Second data beat has d_tlast=1.
   - No DRAIN.
   - d_byte_cnt=128.
4. h_tready held 0 while 6 header-only packets are offered (HDR_FIFO_DEPTH=4):
   - Exactly 4 accepted, then s_tready=0 in SOP and hdr_fifo_cnt=4.
   - Releasing h_tready drains the headers in order.
5. d_tready held 0 mid BODY:
   - Data outputs are stable and s_tready=0.
   - No beat lost or duplicated.
   - A concurrent h_tready toggle has no effect on data.
6. rst_n asserted for 1 cycle in BODY:
   - All valids are 0 the next cycle.
   - hdr_fifo_cnt=0.
   - The following beat produces a header.
